// File: rtl/sparkbox_gpu_pkg.sv
// rtl/sparkbox_gpu_pkg.sv - shared pixel-path constants, colour type and helpers
// Purpose: default widths for the palette path, RGB field slices, rgb_t.
// Ports:   none (package).
package sparkbox_gpu_pkg;

  localparam int DEF_COLOR_W    = 24;
  localparam int DEF_IDX_W      = 8;
  localparam int DEF_FIFO_DEPTH = 16;

  localparam int R_MSB = 23;
  localparam int R_LSB = 16;
  localparam int G_MSB = 15;
  localparam int G_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  typedef logic [DEF_COLOR_W-1:0] rgb_t;

  function automatic rgb_t rgb_pack(input logic [7:0] r, input logic [7:0] g,
                                    input logic [7:0] b);
    rgb_t c;
    c[R_MSB:R_LSB] = r;
    c[G_MSB:G_LSB] = g;
    c[B_MSB:B_LSB] = b;
    return c;
  endfunction

endpackage

// File: rtl/palette_ram.sv
// rtl/palette_ram.sv - 2**IDX_W x COLOR_W palette, 1 write port, 1 sync read port
// Purpose: CPU-writable colour lookup table. A read and a write to the same
//          address in one cycle returns the old colour (read-before-write).
// Ports:   clk_12mhz          clock
//          we/waddr/wdata     write port
//          re/raddr           read request, rdata valid the following cycle
//          rdata              registered read data
module palette_ram #(
  parameter int IDX_W   = 8,
  parameter int COLOR_W = 24
) (
  input  logic               clk_12mhz,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [COLOR_W-1:0] wdata,
  input  logic               re,
  input  logic [IDX_W-1:0]   raddr,
  output logic [COLOR_W-1:0] rdata
);

  logic [COLOR_W-1:0] mem [2**IDX_W];

  // Both updates are non-blocking, so a same-address read samples the
  // pre-write contents.
  always_ff @(posedge clk_12mhz) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/palette_pixel_buffer.sv
// rtl/palette_pixel_buffer.sv - palette lookup feeding a show-ahead colour FIFO
// Purpose: accepts palette indices, looks them up in palette_ram and queues
//          the colours for the LCD pixel writer (2-cycle accept-to-head).
// Optional: PALETTE_UNDERFLOW_CNT_EN adds underflow_cnt / underflow_clr.
// Ports:   clk_12mhz, reset_n (async active-low)
//          idx_valid/idx_data/idx_ready   index stream in
//          pal_we/pal_addr/pal_wdata      palette write port
//          pixel_pop                      writer consumed head pixel
//          rgb/buffer_empty/fill_level    FIFO head and status
//          underflow_cnt/underflow_clr    pops-while-empty counter (optional)
module palette_pixel_buffer
  import sparkbox_gpu_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int IDX_W      = DEF_IDX_W,
  parameter int COLOR_W    = DEF_COLOR_W
) (
  input  logic                          clk_12mhz,
  input  logic                          reset_n,
  input  logic                          idx_valid,
  input  logic [IDX_W-1:0]              idx_data,
  output logic                          idx_ready,
  input  logic                          pal_we,
  input  logic [IDX_W-1:0]              pal_addr,
  input  logic [COLOR_W-1:0]            pal_wdata,
  input  logic                          pixel_pop,
  output logic [COLOR_W-1:0]            rgb,
  output logic                          buffer_empty,
`ifdef PALETTE_UNDERFLOW_CNT_EN
  output logic [15:0]                   underflow_cnt,
  input  logic                          underflow_clr,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]      wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0]      count, cnt_rem;
  logic               s1_v;        // a lookup is in the palette read stage
  logic               ready_q;     // holds idx_ready low until the first cycle after reset
  logic [COLOR_W-1:0] rgb_q;
  logic [COLOR_W-1:0] ram_rdata;
  logic [COLOR_W-1:0] fifo_mem [FIFO_DEPTH];
  logic               accept, do_pop, do_push;

  // Credit includes the in-flight lookup so a full FIFO can never be pushed.
  assign idx_ready = ready_q && ((count + CW'(s1_v)) < CW'(FIFO_DEPTH));
  assign accept    = idx_valid && idx_ready;
  assign do_pop    = pixel_pop && (count != '0);
  assign do_push   = s1_v;
  assign rd_next   = do_pop ? rd_ptr + PW'(1) : rd_ptr;
  assign cnt_rem   = count - CW'(do_pop);

  palette_ram #(
    .IDX_W   (IDX_W),
    .COLOR_W (COLOR_W)
  ) u_palette_ram (
    .clk_12mhz (clk_12mhz),
    .we        (pal_we && reset_n),
    .waddr     (pal_addr),
    .wdata     (pal_wdata),
    .re        (accept),
    .raddr     (idx_data),
    .rdata     (ram_rdata)
  );

  always_ff @(posedge clk_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      s1_v    <= 1'b0;
      ready_q <= 1'b0;
      rgb_q   <= '0;
    end else begin
      ready_q <= 1'b1;
      s1_v    <= accept;
      rd_ptr  <= rd_next;
      count   <= cnt_rem + CW'(do_push);
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      // Registered head: an existing entry if one remains after the pop,
      // otherwise the colour being pushed; with neither, hold the last head.
      if (cnt_rem != '0)
        rgb_q <= fifo_mem[rd_next];
      else if (do_push)
        rgb_q <= ram_rdata;
    end
  end

  always_ff @(posedge clk_12mhz) begin
    if (do_push) fifo_mem[wr_ptr] <= ram_rdata;
  end

  assign rgb          = rgb_q;
  assign buffer_empty = (count == '0);
  assign fill_level   = count;

`ifdef PALETTE_UNDERFLOW_CNT_EN
  logic [15:0] uf_q;

  always_ff @(posedge clk_12mhz or negedge reset_n) begin
    if (!reset_n)
      uf_q <= '0;
    else if (underflow_clr)
      uf_q <= '0;
    else if (pixel_pop && (count == '0) && (uf_q != 16'hFFFF))
      uf_q <= uf_q + 16'd1;
  end

  assign underflow_cnt = uf_q;
`endif

endmodule

// File: tb/tb_palette_pixel_buffer.sv
// tb/tb_palette_pixel_buffer.sv - scoreboard bench for palette_pixel_buffer
module tb_palette_pixel_buffer;
  import sparkbox_gpu_pkg::*;

  logic        clk_12mhz = 1'b0;
  logic        reset_n;
  logic        idx_valid;
  logic [7:0]  idx_data;
  logic        idx_ready;
  logic        pal_we;
  logic [7:0]  pal_addr;
  logic [23:0] pal_wdata;
  logic        pixel_pop;
  logic [23:0] rgb;
  logic        buffer_empty;
  logic [4:0]  fill_level;
`ifdef PALETTE_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
  logic        underflow_clr;
`endif

  int   vectors = 0;
  int   errs    = 0;
  int   n_acc   = 0;
  int   n_pop   = 0;
  rgb_t pal_model [256];
  rgb_t sb [$];

  always #5 clk_12mhz = ~clk_12mhz;

  palette_pixel_buffer #(.FIFO_DEPTH(16), .IDX_W(8), .COLOR_W(24)) dut (
    .clk_12mhz    (clk_12mhz),
    .reset_n      (reset_n),
    .idx_valid    (idx_valid),
    .idx_data     (idx_data),
    .idx_ready    (idx_ready),
    .pal_we       (pal_we),
    .pal_addr     (pal_addr),
    .pal_wdata    (pal_wdata),
    .pixel_pop    (pixel_pop),
    .rgb          (rgb),
    .buffer_empty (buffer_empty),
`ifdef PALETTE_UNDERFLOW_CNT_EN
    .underflow_cnt(underflow_cnt),
    .underflow_clr(underflow_clr),
`endif
    .fill_level   (fill_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic rgb_t pal_init(input int i);
    logic [7:0] b;
    b = 8'(i);
    return rgb_pack(b, b ^ 8'h5A, ~b);
  endfunction

  // One clock: sample at negedge (accept -> push expectation, pop -> compare),
  // then return 1 time unit after the posedge.
  task automatic step();
    @(negedge clk_12mhz);
    if (reset_n && idx_valid && idx_ready) begin
      sb.push_back(pal_model[idx_data]);
      n_acc++;
    end
    if (reset_n && pixel_pop && !buffer_empty) begin
      n_pop++;
      if (sb.size() == 0) chk("pop_unexpected", 32'(rgb), 32'hFFFF_FFFF);
      else chk("pop_order", 32'(rgb), 32'(sb.pop_front()));
    end
    if (reset_n && pal_we) pal_model[pal_addr] = pal_wdata;
    @(posedge clk_12mhz);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while (!buffer_empty && guard < 64) begin
      pixel_pop = 1'b1;
      step();
      guard++;
    end
    pixel_pop = 1'b0;
    chk("drain_empty", 32'(buffer_empty), 32'd1);
  endtask

  initial begin
    int guard;
    reset_n = 1'b0; idx_valid = 1'b0; idx_data = '0; pal_we = 1'b0;
    pal_addr = '0; pal_wdata = '0; pixel_pop = 1'b0;
`ifdef PALETTE_UNDERFLOW_CNT_EN
    underflow_clr = 1'b0;
`endif
    step(); step();
    chk("rst_empty", 32'(buffer_empty), 32'd1);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_ready", 32'(idx_ready), 32'd0);
    reset_n = 1'b1;
    step();
    chk("ready_after_release", 32'(idx_ready), 32'd1);

    // Load palette
    for (int i = 0; i < 256; i++) begin
      pal_we = 1'b1; pal_addr = 8'(i); pal_wdata = pal_init(i);
      step();
    end
    pal_addr = 8'h05; pal_wdata = 24'hFF8000; step();
    pal_addr = 8'h10; pal_wdata = 24'h123456; step();
    pal_we = 1'b0;

    // Latency: accept at cycle 0, head at cycle 2
    idx_valid = 1'b1; idx_data = 8'h05; step();
    idx_valid = 1'b0;
    chk("lat_c1_empty", 32'(buffer_empty), 32'd1);
    step();
    chk("lat_c2_empty", 32'(buffer_empty), 32'd0);
    chk("lat_c2_rgb", 32'(rgb), 32'hFF8000);
    chk("lat_c2_fill", 32'(fill_level), 32'd1);
    pixel_pop = 1'b1; step(); pixel_pop = 1'b0;
    chk("hold_empty", 32'(buffer_empty), 32'd1);
    chk("hold_rgb", 32'(rgb), 32'hFF8000);

    // Fill to depth, no pops
    n_acc = 0; guard = 0;
    idx_valid = 1'b1;
    while (n_acc < 16 && guard < 40) begin
      idx_data = 8'(n_acc);
      step();
      guard++;
    end
    chk("fill_accepts", 32'(n_acc), 32'd16);
    chk("fill_ready_low", 32'(idx_ready), 32'd0);
    idx_data = 8'd99; step(); step();
    chk("fill_no_overflow_acc", 32'(n_acc), 32'd16);
    idx_valid = 1'b0;
    chk("fill_level16", 32'(fill_level), 32'd16);
    chk("fill_ready_full", 32'(idx_ready), 32'd0);
    n_pop = 0;
    drain();
    chk("fill_pops", 32'(n_pop), 32'd16);

    // Steady state at fill_level 4
    idx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin idx_data = 8'(32 + i); step(); end
    idx_valid = 1'b0; step(); step();
    chk("steady_pre_fill", 32'(fill_level), 32'd4);
    idx_valid = 1'b1; idx_data = 8'd40; step();
    chk("steady_first_fill", 32'(fill_level), 32'd4);
    for (int i = 0; i < 100; i++) begin
      idx_data = 8'(41 + i);
      pixel_pop = 1'b1;
      step();
      chk("steady_fill", 32'(fill_level), 32'd4);
    end
    idx_valid = 1'b0;
    drain();

    // Pops while empty
    pixel_pop = 1'b1; step(); step(); step(); pixel_pop = 1'b0;
    chk("uf_fill", 32'(fill_level), 32'd0);
    chk("uf_empty", 32'(buffer_empty), 32'd1);
`ifdef PALETTE_UNDERFLOW_CNT_EN
    chk("uf_cnt", 32'(underflow_cnt), 32'd3);
    underflow_clr = 1'b1; step(); underflow_clr = 1'b0;
    chk("uf_clr", 32'(underflow_cnt), 32'd0);
`endif
    idx_valid = 1'b1; idx_data = 8'd7; step(); idx_valid = 1'b0; step();
    chk("uf_after_rgb", 32'(rgb), 32'(pal_init(7)));
    chk("uf_after_fill", 32'(fill_level), 32'd1);
    drain();

    // Palette read/write collision
    idx_valid = 1'b1; idx_data = 8'h10;
    pal_we = 1'b1; pal_addr = 8'h10; pal_wdata = 24'h00FF00;
    step();
    pal_we = 1'b0;
    step();
    idx_valid = 1'b0;
    step();
    chk("coll_old", 32'(rgb), 32'h123456);
    drain();
    chk("coll_new_last", 32'(rgb), 32'h00FF00);

    // Reset with fill 7 and a lookup in flight
    idx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin idx_data = 8'(60 + i); step(); end
    idx_valid = 1'b0;
    chk("prerst_fill", 32'(fill_level), 32'd7);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_empty", 32'(buffer_empty), 32'd1);
    chk("arst_fill", 32'(fill_level), 32'd0);
    chk("arst_rgb", 32'(rgb), 32'd0);
    chk("arst_ready", 32'(idx_ready), 32'd0);
    pal_we = 1'b1; pal_addr = 8'h05; pal_wdata = 24'hDEAD00;
    step(); step();
    pal_we = 1'b0;
    sb.delete();
    reset_n = 1'b1;
    step();
    chk("rel_ready", 32'(idx_ready), 32'd1);
    chk("rel_empty", 32'(buffer_empty), 32'd1);
    idx_valid = 1'b1; idx_data = 8'h05; step();
    idx_data = 8'h10; step();
    idx_valid = 1'b0; step();
    chk("retain_05", 32'(rgb), 32'hFF8000);
    drain();
    chk("retain_10", 32'(rgb), 32'h00FF00);
    chk("sb_leftover", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
